// File: rtl/mac_pkg.sv
// mac_pkg: width defaults, source FSM states and operand types shared with mac
package mac_pkg;
  localparam int FRAC_W_A = 8;
  localparam int INT_W_A = 8;
  localparam int FRAC_W_B = 8;
  localparam int INT_W_B = 8;
  typedef enum logic [1:0] {IDLE, SEND, DONE} src_state_t;
  typedef logic signed [INT_W_A+FRAC_W_A-1:0] opa_t;
  typedef logic signed [INT_W_B+FRAC_W_B-1:0] opb_t;
endpackage

// File: rtl/mac_operand_src_if.sv
// mac_operand_src_if: A/B operand stream bundle between mac_operand_src and mac
interface mac_operand_src_if #(
  parameter int WA = 16,
  parameter int WB = 16
);
  logic m_valid_a, m_ready_a, m_last_a;
  logic [WA-1:0] m_data_a;
  logic m_valid_b, m_ready_b, m_last_b;
  logic [WB-1:0] m_data_b;
  modport master(output m_valid_a, m_last_a, m_data_a, m_valid_b, m_last_b, m_data_b,
                 input m_ready_a, m_ready_b);
  modport slave(input m_valid_a, m_last_a, m_data_a, m_valid_b, m_last_b, m_data_b,
                output m_ready_a, m_ready_b);
endinterface

// File: rtl/mac_src_chan.sv
// mac_src_chan: one operand stream (index, last, hold register); MAC_SRC_THROTTLE_EN adds a gap counter
module mac_src_chan #(
  parameter int W = 16,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic [ADDR_W:0]       len,
  input  logic [2*ADDR_W+1:0]   tot,
`ifdef MAC_SRC_THROTTLE_EN
  input  logic [3:0]            gap,
`endif
  input  logic [W-1:0]          rd,
  input  logic                  ready,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  valid,
  output logic                  last,
  output logic [W-1:0]          data,
  output logic                  fin
);
  localparam int PW = ADDR_W + 1;
  localparam int TW = 2 * PW;
  logic [TW-1:0] idx;
  logic [PW-1:0] pos, npos;
  logic xfer, fin_beat;
`ifdef MAC_SRC_THROTTLE_EN
  logic [3:0] gcnt;
`endif
  assign xfer = valid && ready;
  assign fin_beat = idx == tot - TW'(1);
  assign npos = pos == len - PW'(1) ? '0 : pos + PW'(1);
  // the buffer address always points at the beat that will be loaded next; wraps mod DEPTH
  assign rd_addr = go ? '0 : ADDR_W'(idx + TW'(1));
  // beat sequencing: load on command, advance on handshake, hold while stalled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      pos <= '0;
      valid <= 1'b0;
      last <= 1'b0;
      data <= '0;
      fin <= 1'b0;
`ifdef MAC_SRC_THROTTLE_EN
      gcnt <= '0;
`endif
    end else if (go) begin
      idx <= '0;
      pos <= '0;
      valid <= 1'b1;
      last <= len == PW'(1);
      data <= rd;
      fin <= 1'b0;
`ifdef MAC_SRC_THROTTLE_EN
      gcnt <= '0;
`endif
    end else if (xfer && fin_beat) begin
      valid <= 1'b0;
      last <= 1'b0;
      fin <= 1'b1;
    end else if (xfer) begin
      idx <= idx + TW'(1);
      pos <= npos;
      last <= npos == len - PW'(1);
      data <= rd;
`ifdef MAC_SRC_THROTTLE_EN
      valid <= gap == 4'd0;
      gcnt <= gap;
`endif
    end
`ifdef MAC_SRC_THROTTLE_EN
    else if (gcnt != 4'd0) begin
      gcnt <= gcnt - 4'd1;
      valid <= gcnt == 4'd1;
    end
`endif
endmodule

// File: rtl/mac_operand_src.sv
// mac_operand_src: buffered dual-stream A/B operand source for mac; MAC_SRC_THROTTLE_EN enables inter-beat gaps
module mac_operand_src
  import mac_pkg::*;
#(
  parameter int frac_width_a = FRAC_W_A,
  parameter int int_width_a = INT_W_A,
  parameter int frac_width_b = FRAC_W_B,
  parameter int int_width_b = INT_W_B,
  parameter int DEPTH = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [int_width_a+frac_width_a-1:0]  wr_a,
  input  logic [int_width_b+frac_width_b-1:0]  wr_b,
  input  logic                                 start,
  input  logic [ADDR_W:0]                      vec_len,
  input  logic [ADDR_W:0]                      num_vec,
  input  logic [3:0]                           gap_cycles,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 cmd_err,
  mac_operand_src_if.master                    m
);
  localparam int WA = int_width_a + frac_width_a;
  localparam int WB = int_width_b + frac_width_b;
  localparam int PW = ADDR_W + 1;
  localparam int TW = 2 * PW;
  logic [WA-1:0] mem_a [DEPTH];
  logic [WB-1:0] mem_b [DEPTH];
  src_state_t state_q, state_d;
  logic [PW-1:0] len_q, len;
  logic [TW-1:0] tot_q;
  logic ok, go, fin_a, fin_b;
  logic [ADDR_W-1:0] ra_a, ra_b;
  assign ok = start && vec_len != '0 && num_vec != '0;
  assign go = state_q == IDLE && ok;
  assign busy = state_q == SEND;
  assign done = state_q == DONE;
  assign len = go ? vec_len : len_q;
  // operand-pair buffer, frozen while a command streams; contents survive reset
  always_ff @(posedge clk)
    if (wr_en && !busy) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  // state register, command capture and zero-length rejection pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      len_q <= '0;
      tot_q <= '0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_err <= state_q == IDLE && start && !ok;
      if (go) begin
        len_q <= vec_len;
        tot_q <= TW'(vec_len) * TW'(num_vec);
      end
    end
  // next state: finish only once both channels have sent their final beat
  always_comb begin
    state_d = state_q;
    state_d = go ? SEND : (busy && fin_a && fin_b) ? DONE : done ? IDLE : state_d;
  end
`ifdef MAC_SRC_THROTTLE_EN
  logic [3:0] gap_q;
  // gap length is fixed for the whole command
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) gap_q <= '0;
    else if (go) gap_q <= gap_cycles;
`else
  logic unused_gap;
  assign unused_gap = ^gap_cycles;
`endif
  mac_src_chan #(.W(WA), .ADDR_W(ADDR_W)) u_chan_a (
    .clk(clk), .reset_n(reset_n), .go(go), .len(len), .tot(tot_q),
`ifdef MAC_SRC_THROTTLE_EN
    .gap(gap_q),
`endif
    .rd(mem_a[ra_a]), .ready(m.m_ready_a), .rd_addr(ra_a),
    .valid(m.m_valid_a), .last(m.m_last_a), .data(m.m_data_a), .fin(fin_a)
  );
  mac_src_chan #(.W(WB), .ADDR_W(ADDR_W)) u_chan_b (
    .clk(clk), .reset_n(reset_n), .go(go), .len(len), .tot(tot_q),
`ifdef MAC_SRC_THROTTLE_EN
    .gap(gap_q),
`endif
    .rd(mem_b[ra_b]), .ready(m.m_ready_b), .rd_addr(ra_b),
    .valid(m.m_valid_b), .last(m.m_last_b), .data(m.m_data_b), .fin(fin_b)
  );
endmodule
